// File: rtl/float_divider_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : float_divider_32bit_seq
// Description : Multi-cycle IEEE-754 single-precision divider (a / b).
//               Radix-2 restoring mantissa division, one quotient bit per
//               clock, round-to-nearest-even, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module float_divider_32bit_seq #(
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DIVIDE = 2'd1;
    localparam logic [1:0] c_ROUND  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic              r_out_valid;
    logic [31:0]       r_result;
    logic [3:0]        r_flags;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mb;
    logic [25:0]       r_rem;
    logic [26:0]       r_quo;
    logic [4:0]        r_cnt;

    // Operand classification; denormals (exp=0) are treated as zero.
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
    assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign w_a_zero = (a[30:23] == 8'h00);
    assign w_b_zero = (b[30:23] == 8'h00);
    assign w_sign   = a[31] ^ b[31];

    logic        w_special;
    logic [31:0] w_spec_result;
    logic [3:0]  w_spec_flags;

    // Special-operand result selection in priority order.
    always_comb begin
        w_special     = 1'b1;
        w_spec_result = NAN_PATTERN;
        w_spec_flags  = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_result = NAN_PATTERN;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_result = NAN_PATTERN;
            w_spec_flags  = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_spec_result = {w_sign, 31'd0};
        end else if (w_b_zero) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
            w_spec_flags  = 4'b0100;
        end else if (w_a_zero) begin
            w_spec_result = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step: subtract divisor when it fits, then shift left.
    logic        w_ge;
    logic [25:0] w_rem_sub;
    logic [25:0] w_rem_next;
    assign w_ge       = (r_rem >= {2'b00, r_mb});
    assign w_rem_sub  = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
    assign w_rem_next = {w_rem_sub[24:0], 1'b0};

    // Normalisation and round-to-nearest-even on the finished quotient.
    logic              w_norm, w_guard, w_sticky, w_inc;
    logic [22:0]       w_mant;
    logic [23:0]       w_mant_rnd;
    logic signed [9:0] w_exp_adj, w_exp_fin;
    logic [31:0]       w_rnd_result;
    logic [3:0]        w_rnd_flags;
    assign w_norm     = r_quo[26];
    assign w_mant     = w_norm ? r_quo[25:3] : r_quo[24:2];
    assign w_guard    = w_norm ? r_quo[2] : r_quo[1];
    assign w_sticky   = (w_norm ? (|r_quo[1:0]) : r_quo[0]) | (r_rem != 26'd0);
    assign w_exp_adj  = w_norm ? r_exp : (r_exp - 10'sd1);
    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + {23'd0, w_inc};
    assign w_exp_fin  = w_mant_rnd[23] ? (w_exp_adj + 10'sd1) : w_exp_adj;

    // Overflow/underflow saturation of the rounded result.
    always_comb begin
        w_rnd_result = {r_sign, w_exp_fin[7:0], w_mant_rnd[22:0]};
        w_rnd_flags  = 4'b0000;
        if (w_exp_fin >= 10'sd255) begin
            w_rnd_result = {r_sign, 8'hFF, 23'd0};
            w_rnd_flags  = 4'b0010;
        end else if (w_exp_fin <= 10'sd0) begin
            w_rnd_result = {r_sign, 31'd0};
            w_rnd_flags  = 4'b0001;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_flags     <= 4'd0;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_mb        <= 24'd0;
            r_rem       <= 26'd0;
            r_quo       <= 27'd0;
            r_cnt       <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_result    <= w_spec_result;
                            r_flags     <= w_spec_flags;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_rem   <= {3'b001, a[22:0]};
                            r_mb    <= {1'b1, b[22:0]};
                            r_quo   <= 27'd0;
                            r_cnt   <= 5'd0;
                            r_exp   <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                            r_state <= c_DIVIDE;
                        end
                    end
                end
                c_DIVIDE: begin
                    r_quo <= {r_quo[25:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd26) begin
                        r_state <= c_ROUND;
                    end
                end
                c_ROUND: begin
                    r_result    <= w_rnd_result;
                    r_flags     <= w_rnd_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_float_divider_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_divider_32bit_seq
// Description : Directed self-checking bench for float_divider_32bit_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_divider_32bit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    float_divider_32bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Wait (bounded) for out_valid, counting clock edges since the accept edge.
    task automatic wait_valid(input string tag, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Issue one divide from idle, check latency/result/flags, optionally
    // stall the consumer for hold cycles, then complete the handshake.
    task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_r, input logic [3:0] exp_f,
                          input int exp_lat, input int hold);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(tag, 0, exp_lat);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_flags"}, 32'(flags), 32'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, result, exp_r);
            chk({tag, "_hold_flags"}, 32'(flags), 32'(exp_f));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);

        // Normal path
        do_div("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0);
        do_div("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 0);
        do_div("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28, 0);
        do_div("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28, 0);

        // Special operands
        do_div("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0, 0);
        do_div("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0, 0);
        do_div("inf_by_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0, 0);
        do_div("nan_in", 32'h7FC00001, 32'h40000000, 32'h7FC00000, 4'b0000, 0, 0);
        do_div("inf_by_two", 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0, 0);
        do_div("one_by_neginf", 32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 0, 0);
        do_div("denorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0, 0);

        // Overflow / underflow
        do_div("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 28, 0);
        do_div("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 0);

        // Consumer stall holds result and blocks new operands
        do_div("stall", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 5);

        // in_valid pulsed during DIVIDE is ignored
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("pulse", 6, 28);
        chk("pulse_result", result, 32'h40400000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("pulse_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset mid-DIVIDE aborts the operation
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'd0);
        do_div("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
